// File: rtl/fft_pkg.sv
// fft_pkg: shared types, defaults and helpers for the FFT input loader.
//   DATA_W_DEF / LOG2N_DEF : default sample width and log2 frame length
//   BANK0 / BANK1          : ping-pong bank indices
//   bitrev()               : reverse the low 'width' bits of a value
package fft_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int LOG2N_DEF    = 4;
   localparam int BITREV_MAX_W = 16;

   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;

   // Reverses bits [width-1:0]; bits at and above 'width' come back zero.
   // Constant indices only, so the loop unrolls to pure wiring.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                      input int width);
      logic [BITREV_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < BITREV_MAX_W; i++) begin
         for (int j = 0; j < BITREV_MAX_W; j++) begin
            if ((i < width) && (i + j == width - 1)) r[i] = v[j];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// fft_sample_bank: one N x DATA_W sample buffer of the ping-pong pair.
//   clk, reset           : clock, async active-high reset (output regs only)
//   we_i/waddr_i/wdata_i : synchronous write port
//   re_i                 : read enable for both read ports
//   raddr_a_i/raddr_b_i  : read addresses
//   rdata_a_o/rdata_b_o  : registered read data, held while re_i is low
module fft_sample_bank
   import fft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LOG2N  = LOG2N_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [LOG2N-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [LOG2N-1:0]  raddr_a_i,
   input  logic [LOG2N-1:0]  raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);

   localparam int N = 1 << LOG2N;

   logic [DATA_W-1:0] mem_q [N];
   logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else if (re_i) begin
         rdata_a_q <= mem_q[raddr_a_i];
         rdata_b_q <= mem_q[raddr_b_i];
      end
   end

   assign rdata_a_o = rdata_a_q;
   assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: writes a real sample stream into a ping-pong buffer in
// bit-reversed order and serves operand pairs to the butterfly stage.
//   clk, reset            : clock, async active-high reset
//   in_valid/in_data      : sample stream in, accepted when in_ready is high
//   in_ready              : write bank is free
//   full                  : read bank holds a complete frame
//   rd_en/rd_addr_a/b     : operand pair request (1-cycle latency)
//   rd_valid/a_out/b_out  : operand pair response; data held between reads
//   frame_done            : consumer releases the current read bank
//   overflow              : sticky, a sample was offered while in_ready was low
module fft_bitrev_loader
   import fft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LOG2N  = LOG2N_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              full,
   input  logic              rd_en,
   input  logic [LOG2N-1:0]  rd_addr_a,
   input  logic [LOG2N-1:0]  rd_addr_b,
   output logic              rd_valid,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   input  logic              frame_done,
   output logic              overflow
);

   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [1:0]       loaded_q, loaded_d;
   logic             overflow_q, overflow_d;
   logic             rd_valid_q;
   logic             rd_sel_q;

   logic             accept, last, release_rd, rd_fire;
   logic [LOG2N-1:0] wr_addr;

   logic [1:0][DATA_W-1:0] bank_a, bank_b;

   assign in_ready   = ~loaded_q[wr_bank_q];
   assign full       = loaded_q[rd_bank_q];
   assign accept     = in_valid & in_ready;
   assign last       = accept & (wr_cnt_q == {LOG2N{1'b1}});
   assign release_rd = frame_done & full;
   // Reads always use the pre-toggle rd_bank, even alongside frame_done.
   assign rd_fire    = rd_en & full;
   assign wr_addr    = LOG2N'(bitrev(BITREV_MAX_W'(wr_cnt_q), LOG2N));

   // A completing write and a release never hit the same bank: the write
   // bank must be unloaded to accept, the read bank loaded to release.
   always_comb begin
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      loaded_d   = loaded_q;
      overflow_d = overflow_q | (in_valid & ~in_ready);
      if (accept) wr_cnt_d = wr_cnt_q + 1'b1;
      if (last) begin
         loaded_d[wr_bank_q] = 1'b1;
         wr_bank_d           = ~wr_bank_q;
      end
      if (release_rd) begin
         loaded_d[rd_bank_q] = 1'b0;
         rd_bank_d           = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt_q   <= '0;
         wr_bank_q  <= BANK0;
         rd_bank_q  <= BANK0;
         loaded_q   <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_sel_q   <= BANK0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         loaded_q   <= loaded_d;
         overflow_q <= overflow_d;
         rd_valid_q <= rd_fire;
         // Remember which bank answered so outputs hold between reads.
         if (rd_fire) rd_sel_q <= rd_bank_q;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_sample_bank #(
         .DATA_W (DATA_W),
         .LOG2N  (LOG2N)
      ) u_bank (
         .clk       (clk),
         .reset     (reset),
         .we_i      (accept & (wr_bank_q == 1'(b))),
         .waddr_i   (wr_addr),
         .wdata_i   (in_data),
         .re_i      (rd_fire & (rd_bank_q == 1'(b))),
         .raddr_a_i (rd_addr_a),
         .raddr_b_i (rd_addr_b),
         .rdata_a_o (bank_a[b]),
         .rdata_b_o (bank_b[b])
      );
   end

   assign a_out    = bank_a[rd_sel_q];
   assign b_out    = bank_b[rd_sel_q];
   assign rd_valid = rd_valid_q;
   assign overflow = overflow_q;

endmodule

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
- Input stage directly upstream of complex_butterfly in the FFT datapath.
- Accepts a stream of real samples and writes each frame into a ping-pong buffer in bit-reversed order.
- Asserts full when a frame is ready, then serves a/b operand pairs at addresses chosen by the butterfly/index logic.
- The write side fills the second bank while the consumer reads the first.

Parameters:
DATA_W, 8, sample width in bits
LOG2N, 4, log2 of frame length; N = 2**LOG2N samples per frame

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  producer presents in_data this cycle
in_data  in  DATA_W  input sample
in_ready  out  1  loader can accept a sample this cycle
full  out  1  a complete bit-reversed frame is available to read
rd_en  in  1  read request for an operand pair
rd_addr_a  in  LOG2N  read address of operand a
rd_addr_b  in  LOG2N  read address of operand b
rd_valid  out  1  a_out/b_out hold the data for the previous cycle's request
a_out  out  DATA_W  operand a
b_out  out  DATA_W  operand b
frame_done  in  1  single-cycle pulse from consumer: current read bank is released
overflow  out  1  sticky; a sample was offered while in_ready was low

Behaviour:
- Reset, asynchronous: in_ready=1, full=0, rd_valid=0, a_out=0, b_out=0, overflow=0.
- Reset also clears: wr_cnt=0, wr_bank=0, rd_bank=0, loaded[1:0]=0. RAM contents are not reset.
- in_ready = ~loaded[wr_bank].
- A sample is accepted when in_valid & in_ready. It is written to bank wr_bank at address bitrev(wr_cnt), a LOG2N-bit reversal. wr_cnt then increments.
- When the accepted sample has wr_cnt = N-1, on that edge: loaded[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- full = loaded[rd_bank]. It rises in the cycle after the edge that accepted the frame's last sample.
- Read path:
  - When rd_en & full, on the next edge a_out <= bank[rd_bank][rd_addr_a], b_out <= bank[rd_bank][rd_addr_b], rd_valid <= 1. Latency is 1 cycle.
  - rd_addr_a = rd_addr_b is legal; both outputs then carry the same word.
  - When rd_en & ~full: rd_valid <= 0 and a_out/b_out hold their values.
  - When rd_en is low: rd_valid <= 0 and a_out/b_out hold their values.
- frame_done & full: loaded[rd_bank] <= 0 and rd_bank toggles. frame_done & ~full is ignored.
- Simultaneous completion of a write frame and frame_done: both updates apply on the same edge, since they target different banks.
  - Consequence when the other bank just completed: full stays high with the new rd_bank.
- Both banks loaded: in_ready=0, samples are dropped, overflow <= 1 until reset. wr_cnt does not advance on dropped samples.
- rd_en together with frame_done: the read uses the pre-toggle rd_bank.
- Reset mid-frame: the partial frame is discarded, and the next accepted sample goes to bank 0, address 0.
- Frames alternate banks strictly: frame k is written to bank k mod 2 and read from bank k mod 2.

Decomposition:
- Shared package fft_pkg:
  - DATA_W/LOG2N defaults.
  - bitrev function, parameterised on LOG2N.
  - Bank-index constants.
- Sub-module fft_sample_bank: one instance per bank.
  - 1 synchronous write port, 2 synchronous read ports, N x DATA_W.
- The top level holds the counter, the bank pointers, the loaded flags, handshake/full logic and output muxing.

Test Plan (DATA_W=8, LOG2N=4):
- Fill and read:
  - Stimulus: stream samples 0..15 with in_valid held high.
  - Response: full=1 in the cycle after sample 15 is accepted.
  - Read a=0,b=1 -> next cycle a_out=0, b_out=8, rd_valid=1.
  - Read a=1,b=2 -> a_out=8, b_out=4.
  - Read a=15,b=15 -> both 15.
- Backpressure/overflow:
  - Stimulus: stream 32 samples with no frame_done.
  - Response: in_ready=0 after the 32nd sample; sample 33 is dropped and overflow=1.
  - Pulse frame_done -> in_ready=1, full stays 1, and reading addr 0 returns 16.
- Spurious pulses: frame_done and rd_en while full=0 -> no state change, rd_valid stays 0.
- Simultaneous events:
  - Stimulus: frame 0 loaded and frame 1's 16th sample accepted in the same cycle as frame_done.
  - Response: full remains 1, and reading addr 1 returns 24.
- Reset mid-frame:
  - Stimulus: assert reset after 7 samples of a frame, then load samples 100..115.
  - Response: immediately after reset, all outputs are 0. After the reload, reading addr 0/1 returns 100/108.
